// File: rtl/esm_pkg.sv
// esm_pkg: shared entry-state encoding, index-width helper and settle default
// for the ESM issue scheduler.
package esm_pkg;
    typedef enum logic [1:0] {ESM_FREE, ESM_WAIT, ESM_READY, ESM_ISSUED} esm_state_e;
    localparam int ESM_SETTLE = 3;
    function automatic int esm_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/esm_prio_enc.sv
// esm_prio_enc: lowest-index-first priority encoder with a found flag.
module esm_prio_enc
    import esm_pkg::*;
#(
    parameter  int bs = 16,
    localparam int IW = esm_idx_w(bs)
) (
    input  logic [0:bs-1]  i_req,
    output logic [IW-1:0]  o_idx,
    output logic           o_found
);
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IW'(i);
                o_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/esm_issue_scheduler.sv
// esm_issue_scheduler: instruction buffer owner; allocates slots, waits for the
// dependency analyser to settle, and issues independent entries one per cycle.
module esm_issue_scheduler
    import esm_pkg::*;
#(
    parameter  int Instruction_word_size = 32,
    parameter  int bs                    = 16,
    parameter  int SETTLE                = ESM_SETTLE,
    localparam int IW                    = esm_idx_w(bs),
    localparam int CW                    = esm_idx_w(SETTLE)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [Instruction_word_size-1:0] in_instr,
    output logic                             in_ready,
    output logic                             alloc_fire,
    output logic [IW-1:0]                    alloc_index,
    output logic [0:bs-1]                    valid_entries,
    input  logic [0:bs-1]                    independent_instr,
    output logic                             issue_valid,
    input  logic                             issue_ready,
    output logic [Instruction_word_size-1:0] issue_instr,
    output logic [IW-1:0]                    issue_index,
    input  logic                             retire_valid,
    input  logic [IW-1:0]                    retire_index,
    output logic                             err
);
    esm_state_e                       r_state [bs];
    logic [CW-1:0]                    r_cnt   [bs];
    logic [Instruction_word_size-1:0] r_mem   [bs];
    logic                             r_issue_valid;
    logic [IW-1:0]                    r_issue_idx;
    logic [Instruction_word_size-1:0] r_issue_instr;
    logic [IW-1:0]                    r_last_alloc;
    logic                             r_err;
    logic [0:bs-1]                    w_free;
    logic [0:bs-1]                    w_elig;
    logic [IW-1:0]                    w_free_idx;
    logic [IW-1:0]                    w_elig_idx;
    logic                             w_free_found;
    logic                             w_elig_found;
    logic                             w_load;
    logic                             w_issue_ld;
    logic                             w_ret_ok;

    always_comb begin
        w_free = '0;
        w_elig = '0;
        for (int i = 0; i < bs; i++) begin
            w_free[i] = (r_state[i] == ESM_FREE);
            w_elig[i] = (r_state[i] == ESM_READY) && independent_instr[i];
        end
    end

    esm_prio_enc #(.bs(bs)) u_free_enc (.i_req(w_free), .o_idx(w_free_idx), .o_found(w_free_found));
    esm_prio_enc #(.bs(bs)) u_elig_enc (.i_req(w_elig), .o_idx(w_elig_idx), .o_found(w_elig_found));

    assign valid_entries = ~w_free;
    assign in_ready      = w_free_found;
    assign alloc_fire    = in_valid & w_free_found;
    assign alloc_index   = w_free_found ? w_free_idx : r_last_alloc;
    // The issue register refills whenever it is empty or being accepted.
    assign w_load        = !r_issue_valid || issue_ready;
    assign w_issue_ld    = w_load && w_elig_found;
    assign w_ret_ok      = retire_valid && (r_state[retire_index] == ESM_ISSUED);
    assign issue_valid   = r_issue_valid;
    assign issue_index   = r_issue_idx;
    assign issue_instr   = r_issue_instr;
    assign err           = r_err;

    // Alloc, issue and retire act on disjoint states, so one slot sees at most one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < bs; i++) begin
                r_state[i] <= ESM_FREE;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < bs; i++) begin
                if (alloc_fire && alloc_index == IW'(i)) begin
                    r_state[i] <= (SETTLE > 1) ? ESM_WAIT : ESM_READY;
                    r_cnt[i]   <= CW'(SETTLE - 1);
                end else if (r_state[i] == ESM_WAIT) begin
                    r_cnt[i]   <= (r_cnt[i] == '0) ? '0 : r_cnt[i] - CW'(1);
                    if (r_cnt[i] <= CW'(1))
                        r_state[i] <= ESM_READY;
                end else if (w_issue_ld && w_elig_idx == IW'(i)) begin
                    r_state[i] <= ESM_ISSUED;
                end else if (w_ret_ok && retire_index == IW'(i)) begin
                    r_state[i] <= ESM_FREE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire)
            r_mem[alloc_index] <= in_instr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue_valid <= 1'b0;
            r_issue_idx   <= '0;
            r_issue_instr <= '0;
            r_last_alloc  <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_load)
                r_issue_valid <= w_elig_found;
            if (w_issue_ld) begin
                r_issue_idx   <= w_elig_idx;
                r_issue_instr <= r_mem[w_elig_idx];
            end
            if (w_free_found)
                r_last_alloc <= w_free_idx;
            if (retire_valid && !w_ret_ok)
                r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_esm_issue_scheduler.sv
// tb_esm_issue_scheduler: directed bench for a 4-entry scheduler with SETTLE=3;
// inputs change 1 ns after a rising edge and outputs are checked 1 ns later.
module tb_esm_issue_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic        alloc_fire;
    logic [1:0]  alloc_index;
    logic [0:3]  valid_entries;
    logic [0:3]  ind = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [31:0] issue_instr;
    logic [1:0]  issue_index;
    logic        retire_valid = 1'b0;
    logic [1:0]  retire_index = '0;
    logic        err;
    int          n_chk = 0;
    int          n_pass = 0;

    esm_issue_scheduler #(.Instruction_word_size(32), .bs(4), .SETTLE(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .alloc_fire(alloc_fire), .alloc_index(alloc_index),
        .valid_entries(valid_entries), .independent_instr(ind),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_instr(issue_instr), .issue_index(issue_index),
        .retire_valid(retire_valid), .retire_index(retire_index), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_valid_entries", 32'(valid_entries), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_alloc_index", 32'(alloc_index), 0);
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_err", 32'(err), 0);
        repeat (2) cyc();
        rst = 1'b1;
        ind = '1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            in_valid = 1'b1;
            in_instr = 32'hA000_0000 + 32'(k);
            #1;
            chk("fill_alloc_index", 32'(alloc_index), 32'(k));
            chk("fill_alloc_fire", 32'(alloc_fire), 1);
            if (k == 3) chk("issue_not_before_settle", 32'(issue_valid), 0);
        end
        cyc();
        in_valid = 1'b0;
        issue_ready = 1'b1;
        #1;
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_valid_entries", 32'(valid_entries), 32'hF);
        chk("first_issue_valid", 32'(issue_valid), 1);
        chk("first_issue_index", 32'(issue_index), 0);
        chk("first_issue_instr", issue_instr, 32'hA000_0000);
        for (int k = 0; k < 5; k++) begin
            cyc();
            issue_ready = 1'b0;
            ind = (k % 2 == 0) ? 4'b0000 : 4'b1111;
            #1;
            chk("hold_issue_valid", 32'(issue_valid), 1);
            chk("hold_issue_index", 32'(issue_index), 1);
            chk("hold_issue_instr", issue_instr, 32'hA000_0001);
        end
        cyc();
        issue_ready = 1'b1;
        ind = '0;
        cyc();
        issue_ready = 1'b0;
        retire_valid = 1'b1;
        retire_index = 2'd0;
        #1;
        chk("accept_clears_valid", 32'(issue_valid), 0);
        cyc();
        retire_index = 2'd1;
        #1;
        chk("retire0_frees_slot", 32'(valid_entries[0]), 0);
        chk("retire0_alloc_index", 32'(alloc_index), 0);
        cyc();
        retire_valid = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'hB000_0000;
        #1;
        chk("refill0_alloc_index", 32'(alloc_index), 0);
        cyc();
        in_instr = 32'hB000_0001;
        #1;
        chk("refill1_alloc_index", 32'(alloc_index), 1);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("refull_in_ready", 32'(in_ready), 0);
        chk("full_alloc_index_held", 32'(alloc_index), 1);
        cyc();
        cyc();
        ind = '0;
        ind[1] = 1'b1;
        #1;
        chk("sel_idle", 32'(issue_valid), 0);
        cyc();
        issue_ready = 1'b1;
        #1;
        chk("sel_only1_index", 32'(issue_index), 1);
        chk("sel_only1_instr", issue_instr, 32'hB000_0001);
        cyc();
        issue_ready = 1'b0;
        ind[0] = 1'b1;
        #1;
        chk("sel_no_reissue1", 32'(issue_valid), 0);
        cyc();
        issue_ready = 1'b1;
        #1;
        chk("sel_bit0_valid", 32'(issue_valid), 1);
        chk("sel_bit0_index", 32'(issue_index), 0);
        chk("sel_bit0_instr", issue_instr, 32'hB000_0000);
        cyc();
        issue_ready = 1'b0;
        ind[2] = 1'b1;
        #1;
        chk("sel_no_reissue01", 32'(issue_valid), 0);
        cyc();
        issue_ready = 1'b1;
        #1;
        chk("sel_bit2_index", 32'(issue_index), 2);
        chk("sel_bit2_instr", issue_instr, 32'hA000_0002);
        cyc();
        issue_ready = 1'b0;
        ind = '0;
        retire_valid = 1'b1;
        retire_index = 2'd2;
        in_valid = 1'b1;
        in_instr = 32'hC000_0002;
        #1;
        chk("retire_cycle_in_ready", 32'(in_ready), 0);
        chk("retire_cycle_alloc_fire", 32'(alloc_fire), 0);
        cyc();
        retire_valid = 1'b0;
        #1;
        chk("reuse_alloc_fire", 32'(alloc_fire), 1);
        chk("reuse_alloc_index", 32'(alloc_index), 2);
        chk("retire_ok_no_err", 32'(err), 0);
        cyc();
        in_valid = 1'b0;
        retire_valid = 1'b1;
        retire_index = 2'd2;
        cyc();
        retire_valid = 1'b0;
        ind[2] = 1'b1;
        #1;
        chk("bad_retire_err", 32'(err), 1);
        chk("bad_retire_slot_kept", 32'(valid_entries[2]), 1);
        cyc();
        #1;
        chk("wait_slot_not_issued_early", 32'(issue_valid), 0);
        cyc();
        #1;
        chk("wait_slot_issue_index", 32'(issue_index), 2);
        chk("wait_slot_issue_instr", issue_instr, 32'hC000_0002);
        chk("err_sticky", 32'(err), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_issue_valid", 32'(issue_valid), 0);
        chk("async_rst_valid_entries", 32'(valid_entries), 0);
        chk("async_rst_in_ready", 32'(in_ready), 1);
        chk("async_rst_err", 32'(err), 0);
        chk("async_rst_alloc_index", 32'(alloc_index), 0);
        #20;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
